div_unit: RTL and testbench

- Multi-cycle iterative (radix-2 restoring) 32-bit divider in the EX stage, serving DIV/DIVU.
- Drives the `stall` and `done` handshake that the hazard controller consumes. While `stall` is high, the controller freezes F/D/E.
- `done` pulses for one cycle with the quotient and remainder valid, so HI/LO are written as the instruction advances.

---
 rtl/div_unit_pkg.sv | 14 +
 rtl/div_unit_if.sv | 27 ++
 rtl/div_unit_step.sv | 25 ++
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: default width, counter width
// and the FSM state encoding.
package div_unit_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_COUNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Divider handshake bundle between the EX stage/hazard controller (master)
// and the divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor, cancel,
    input  stall, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor, cancel,
    output stall, done, quotient, remainder
  );

endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             quo_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder is always below the divisor, so the shifted value
  // needs exactly one extra bit and the restored result fits back in WIDTH.
  assign shifted = {rem_in, dividend_bit};
  assign trial   = shifted - {1'b0, divisor};
  assign quo_bit = ~trial[WIDTH];
  assign rem_out = quo_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU with stall/done pipeline
// handshake, sign fixup and divide-by-zero handling.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] raw_dividend_reg;
  logic             neg_quo_reg;
  logic             neg_rem_reg;
  logic             div_zero_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;

  logic             accept;
  logic             step_en;
  logic             last_step;
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH-1:0] step_rem;
  logic             step_quo_bit;
  logic [WIDTH-1:0] final_quo;
  logic [WIDTH-1:0] quo_result;
  logic [WIDTH-1:0] rem_result;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem_reg),
    .divisor     (divisor_reg),
    .dividend_bit(quo_reg[WIDTH-1]),
    .rem_out     (step_rem),
    .quo_bit     (step_quo_bit)
  );

  assign accept    = (state_reg == DIV_IDLE) && bus.start && !bus.cancel;
  assign step_en   = (state_reg == DIV_BUSY) && !bus.cancel;
  assign last_step = (count_reg == CNT_W'(WIDTH - 1));

  assign dividend_neg = bus.is_signed && bus.dividend[WIDTH-1];
  assign divisor_neg  = bus.is_signed && bus.divisor[WIDTH-1];
  assign dividend_abs = dividend_neg ? -bus.dividend : bus.dividend;
  assign divisor_abs  = divisor_neg ? -bus.divisor : bus.divisor;

  // Final quotient includes the bit produced by the step in flight.
  assign final_quo = {quo_reg[WIDTH-2:0], step_quo_bit};

  always_comb begin
    quo_result = neg_quo_reg ? -final_quo : final_quo;
    rem_result = neg_rem_reg ? -step_rem : step_rem;
    if (div_zero_reg) begin
      quo_result = '1;
      rem_result = raw_dividend_reg;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= DIV_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; cancel overrides everything but reset
  always_comb begin
    state_next = state_reg;
    if (bus.cancel) begin
      state_next = DIV_IDLE;
    end else begin
      unique case (state_reg)
        DIV_IDLE: if (bus.start) state_next = DIV_BUSY;
        DIV_BUSY: if (last_step) state_next = DIV_DONE;
        DIV_DONE: state_next = DIV_IDLE;
        default:  state_next = DIV_IDLE;
      endcase
    end
  end

  // Output logic: stall rises in the accept cycle itself so E freezes at once
  always_comb begin
    bus.stall = 1'b0;
    bus.done  = 1'b0;
    unique case (state_reg)
      DIV_IDLE: bus.stall = bus.start && !bus.cancel;
      DIV_BUSY: bus.stall = !bus.cancel;
      DIV_DONE: bus.done  = !bus.cancel;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg        <= '0;
      rem_reg          <= '0;
      quo_reg          <= '0;
      divisor_reg      <= '0;
      raw_dividend_reg <= '0;
      neg_quo_reg      <= 1'b0;
      neg_rem_reg      <= 1'b0;
      div_zero_reg     <= 1'b0;
      quotient_reg     <= '0;
      remainder_reg    <= '0;
    end else if (accept) begin
      count_reg        <= '0;
      rem_reg          <= '0;
      quo_reg          <= dividend_abs;
      divisor_reg      <= divisor_abs;
      raw_dividend_reg <= bus.dividend;
      neg_quo_reg      <= dividend_neg ^ divisor_neg;
      neg_rem_reg      <= dividend_neg;
      div_zero_reg     <= (bus.divisor == '0);
    end else if (step_en) begin
      count_reg <= count_reg + 1'b1;
      rem_reg   <= step_rem;
      quo_reg   <= final_quo;
      if (last_step) begin
        quotient_reg  <= quo_result;
        remainder_reg <= rem_result;
      end
    end
  end

  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results and done
// cycles, a negedge monitor pops and compares on every done pulse.
module tb_div_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division on 64-bit values, with the
  // architectural divide-by-zero result.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit s);
    exp_t e;
    longint sa, sb2, sq, sr;
    logic [63:0] uq, ur;
    e.cyc = 0;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
    end else if (s) begin
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      sq  = sa / sb2;
      sr  = sa % sb2;
      e.q = sq[W-1:0];
      e.r = sr[W-1:0];
    end else begin
      uq  = {32'd0, a} / {32'd0, b};
      ur  = {32'd0, a} % {32'd0, b};
      e.q = uq[W-1:0];
      e.r = ur[W-1:0];
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst && bus.done) begin
      checks++;
      if (bus.stall) begin
        errors++;
        $display("FAIL done_with_stall: stall=1 expected 0 at cycle %0d", cyc);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with nothing pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("done @%0d q=%h r=%h (exp q=%h r=%h @%0d)",
                 cyc, bus.quotient, bus.remainder, e.q, e.r, e.cyc);
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL done_cycle: got %0d expected %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    exp_t e;
    e = model(a, b, s);
    e.cyc = cyc + W + 1;
    last_q = e.q;
    last_r = e.r;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < W + 8 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d results pending at cycle %0d", sb.size(), cyc);
      sb.delete();
    end
  endtask

  // Called just after a rising edge; start is high for exactly one cycle.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    push_exp(a, b, s);
    @(negedge clk);
    check("stall_on_accept", {31'd0, bus.stall}, 32'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("held_quotient", bus.quotient, last_q);
    check("held_remainder", bus.remainder, last_r);
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit s;
    checks = 0;
    errors = 0;
    last_q = '0;
    last_r = '0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_quotient", bus.quotient, 32'd0);
    check("reset_remainder", bus.remainder, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div(32'h1234_5678, 32'd0, 1'b0);
    run_div(32'hF000_0001, 32'd0, 1'b1);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0);

    // Back-to-back: start held through DONE, second op accepted next cycle
    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend = 32'd200;
    bus.divisor = 32'd10;
    push_exp(32'd200, 32'd10, 1'b0);
    begin
      int k;
      for (k = 0; k < W + 8 && !bus.done; k++) @(negedge clk);
      if (!bus.done) begin
        checks++;
        errors++;
        $display("FAIL b2b_first_done: no done within %0d cycles", k);
      end
    end
    @(posedge clk);
    #1;
    bus.dividend = 32'd9;
    bus.divisor = 32'd4;
    push_exp(32'd9, 32'd4, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain();

    // Cancel in BUSY at cycle 10, then a fresh start at cycle 12
    begin
      logic [W-1:0] keep_q, keep_r;
      keep_q = last_q;
      keep_r = last_r;
      bus.start = 1'b1;
      bus.is_signed = 1'b0;
      bus.dividend = 32'd5000;
      bus.divisor = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.cancel = 1'b1;
      @(negedge clk);
      check("cancel_stall", {31'd0, bus.stall}, 32'd0);
      check("cancel_done", {31'd0, bus.done}, 32'd0);
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      check("cancel_quotient", bus.quotient, keep_q);
      check("cancel_remainder", bus.remainder, keep_r);
      @(posedge clk);
      #1;
      run_div(32'd1000, 32'd33, 1'b0);
    end

    // Asynchronous reset mid-operation
    bus.start = 1'b1;
    bus.is_signed = 1'b1;
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor = 32'd17;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_stall", {31'd0, bus.stall}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_quotient", bus.quotient, 32'd0);
    check("arst_remainder", bus.remainder, 32'd0);
    last_q = '0;
    last_r = '0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (W + 4) @(posedge clk);
    #1;
    check("idle_after_rst_stall", {31'd0, bus.stall}, 32'd0);
    check("idle_after_rst_quotient", bus.quotient, 32'd0);

    // Randomized operands, biased towards small and zero divisors
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      case ($urandom_range(3))
        0: b = 32'($urandom_range(15));
        1: b = -32'($urandom_range(15));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(1));
      run_div(a, b, s);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
